// File: rtl/fpdiv_seq.sv
// fpdiv_seq: sequential restoring binary64 divider, one quotient bit per cycle, round half-up.
module fpdiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] N1,
  input  logic [63:0] N2,
  output logic        busy,
  output logic        done,
  output logic [63:0] out
);
  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
  state_t      state;
  logic        sign;
  logic [10:0] e1, e2;
  logic [53:0] r;
  logic [52:0] d;
  logic [54:0] q;
  logic [5:0]  cnt;
  logic        ge, rb;
  logic [53:0] diff;
  logic [51:0] m;
  logic [52:0] sum;
  logic [10:0] exp_n;
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  assign ge    = r >= {1'b0, d};
  assign diff  = r - {1'b0, d};
  assign m     = q[54] ? q[53:2] : q[52:1];
  assign rb    = q[54] ? q[1] : q[0];
  assign sum   = {1'b0, m} + {52'b0, rb};
  // a rounding carry out of the mantissa bumps the exponent and clears the fraction
  assign exp_n = e1 - e2 + (q[54] ? 11'd1023 : 11'd1022) + {10'b0, sum[52]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      cnt   <= '0;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      sign  <= 1'b0;
      e1    <= '0;
      e2    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sign <= N1[63] ^ N2[63];
          e1   <= N1[62:52];
          e2   <= N2[62:52];
          r    <= {2'b01, N1[51:0]};
          d    <= {1'b1, N2[51:0]};
          q    <= '0;
          cnt  <= 6'd54;
          if (N2[62:0] == '0) begin
            out   <= {N1[63] ^ N2[63], 11'h7FF, 52'b0};
            state <= DONE;
          end else if (N1[62:0] == '0) begin
            out   <= {N1[63] ^ N2[63], 63'b0};
            state <= DONE;
          end else state <= DIV;
        end
        DIV: begin
          r     <= ge ? {diff[52:0], 1'b0} : {r[52:0], 1'b0};
          q     <= {q[53:0], ge};
          cnt   <= cnt - 6'd1;
          state <= cnt == 6'd0 ? ROUND : DIV;
        end
        ROUND: begin
          out   <= {sign, exp_n, sum[52] ? 52'b0 : sum[51:0]};
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpdiv_seq.sv
// tb_fpdiv_seq: directed and random checks of fpdiv_seq against an arithmetic reference model.
module tb_fpdiv_seq;
  logic        clk = 0, rst, start, busy, done;
  logic [63:0] N1, N2, out;
  int          total = 0, bad = 0;
  localparam logic [63:0] ONE = 64'h3FF0000000000000, SIX = 64'h4018000000000000,
                          MTWO = 64'hC000000000000000, THREE = 64'h4008000000000000;

  fpdiv_seq dut (.clk(clk), .rst(rst), .start(start), .N1(N1), .N2(N2),
                 .busy(busy), .done(done), .out(out));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // quotient computed by wide integer division, then normalized and rounded half-up
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
    logic         s;
    logic [127:0] qq, mm;
    int           e;
    s = a[63] ^ b[63];
    if (b[62:0] == '0) return {s, 11'h7FF, 52'b0};
    if (a[62:0] == '0) return {s, 63'b0};
    qq = (128'({1'b1, a[51:0]}) << 54) / 128'({1'b1, b[51:0]});
    if (qq >= (128'd1 << 54)) begin
      mm = (qq >> 2) % (128'd1 << 52) + 128'(qq[1]);
      e  = 1023;
    end else begin
      mm = (qq >> 1) % (128'd1 << 52) + 128'(qq[0]);
      e  = 1022;
    end
    e = e + int'(a[62:52]) - int'(b[62:52]);
    if (mm == (128'd1 << 52)) begin
      mm = '0;
      e++;
    end
    e = ((e % 2048) + 2048) % 2048;
    return {s, 11'(e), mm[51:0]};
  endfunction

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic [63:0] res, output logic b1);
    @(negedge clk);
    N1 = a; N2 = b; start = 1;
    @(negedge clk);
    start = 0; lat = 1; b1 = busy;
    N1 = {$urandom, $urandom}; N2 = {$urandom, $urandom};
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      N1 = {$urandom, $urandom};
    end
    res = out;
  endtask

  initial begin
    int          lat, nd, dl;
    logic [63:0] res, a, b, exp;
    logic        b1;
    rst = 1; start = 0; N1 = '0; N2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", out, 64'd0);
    rst = 0;

    run_op(ONE, ONE, lat, res, b1);
    chk("one_lat", 64'(lat), 64'd57);
    chk("one_out", res, ONE);
    chk("one_busy", 64'(b1), 64'd1);
    repeat (5) @(negedge clk);
    chk("hold_out", out, ONE);
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    run_op(SIX, MTWO, lat, res, b1);
    chk("six_out", res, 64'hC008000000000000);
    run_op(ONE, THREE, lat, res, b1);
    chk("third_out", res, 64'h3FD5555555555555);
    run_op(64'h4000000000000000, 64'h0, lat, res, b1);
    chk("div0_lat", 64'(lat), 64'd1);
    chk("div0_out", res, 64'h7FF0000000000000);
    run_op(64'h8000000000000000, 64'h4014000000000000, lat, res, b1);
    chk("zero_lat", 64'(lat), 64'd1);
    chk("zero_out", res, 64'h8000000000000000);
    run_op(64'h3FFFFFFFFFFFFFFF, 64'h3FF0000000000001, lat, res, b1);
    chk("carry_out", res, model(64'h3FFFFFFFFFFFFFFF, 64'h3FF0000000000001));

    // starts while busy must be dropped, not queued
    @(negedge clk);
    N1 = ONE; N2 = ONE; start = 1;
    nd = 0; dl = 0; res = '0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      start = (j == 10 || j == 57);
      N1 = {$urandom, $urandom}; N2 = {$urandom, $urandom};
      if (done) begin
        nd++; dl = j; res = out;
      end
    end
    start = 0;
    chk("busy_start_ndone", 64'(nd), 64'd1);
    chk("busy_start_lat", 64'(dl), 64'd57);
    chk("busy_start_out", res, ONE);
    chk("busy_start_idle", 64'(busy), 64'd0);

    // reset mid-operation aborts without a done pulse
    @(negedge clk);
    N1 = SIX; N2 = MTWO; start = 1;
    nd = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      start = 0;
      rst = (j == 20);
      if (j == 21) begin
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out", out, 64'd0);
      end
      if (done) nd++;
    end
    chk("abort_ndone", 64'(nd), 64'd0);

    for (int i = 0; i < 24; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 8 == 3) b[62:0] = '0;
      if (i % 8 == 5) a[62:0] = '0;
      exp = model(a, b);
      run_op(a, b, lat, res, b1);
      chk($sformatf("rand%0d_out a=%h b=%h", i, a, b), res, exp);
      chk($sformatf("rand%0d_lat", i), 64'(lat),
          (b[62:0] == '0 || a[62:0] == '0) ? 64'd1 : 64'd57);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpdiv_seq.md
FPDIV_SEQ -- requirements
Module: fpdiv_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for IEEE-754 binary64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request pulse; operands are sampled only on an edge where start=1 and the FSM is in IDLE.
REQ-005 N1  input  64  dividend (binary64).
REQ-006 N2  input  64  divisor (binary64).
REQ-007 busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 done  output  1  one-cycle pulse; out is valid in that cycle.
REQ-009 out  output  64  registered quotient; holds its value until the next done.

Function
REQ-010 The FSM SHALL have exactly four states: IDLE, DIV, ROUND, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-011 IDLE + start: the block SHALL latch sign = N1[63]^N2[63], E1 = N1[62:52], E2 = N2[62:52], the 54-bit remainder R = {1'b1, N1[51:0]}, the 53-bit divisor D = {1'b1, N2[51:0]}, Q = 0, and the 6-bit counter = 54.
REQ-012 Zero divisor (N2[62:0]==0) at acceptance: out SHALL load {sign, 11'h7FF, 52'b0}, and the FSM SHALL go IDLE->DONE.
REQ-013 Zero dividend (N1[62:0]==0, N2 nonzero) at acceptance: out SHALL load {sign, 63'b0}, and the FSM SHALL go IDLE->DONE.
REQ-014 Otherwise the FSM SHALL go IDLE->DIV.
REQ-015 DIV, one quotient bit per cycle (restoring):
  - if R >= D: qbit = 1 and R <- (R - D) << 1;
  - else: qbit = 0 and R <- R << 1;
  - Q <- {Q[53:0], qbit}; the counter decrements;
  - on the cycle in which the counter is 0, the FSM SHALL go DIV->ROUND (exactly 55 DIV cycles).
REQ-016 The 55-bit Q SHALL equal floor(1.M1 / 1.M2 * 2^54); Q[54] = 1 iff 1.M1 >= 1.M2.
REQ-017 ROUND, normalize:
  - if Q[54]: m = Q[53:2], rb = Q[1], exp = E1 - E2 + 1023;
  - else: m = Q[52:1], rb = Q[0], exp = E1 - E2 + 1022.
REQ-018 ROUND, round half-up: the 53-bit sum {1'b0, m} + rb SHALL be formed; on carry (bit 52 set), the mantissa SHALL be 0 and exp SHALL increment.
REQ-019 ROUND SHALL load out = {sign, exp, mantissa} and go ROUND->DONE.
REQ-020 Exponent arithmetic SHALL be 11-bit modulo; there is no overflow, underflow, subnormal, NaN or Inf-operand handling.
REQ-021 DONE SHALL last exactly one cycle, then DONE->IDLE unconditionally.
REQ-022 start while busy (DIV, ROUND or DONE) SHALL be ignored and SHALL NOT be queued; operand changes while busy SHALL have no effect.
REQ-023 Latency, normal path: start sampled at edge k -> DIV cycles k+1..k+55, ROUND k+56, done high in cycle k+57; the next start is accepted at edge k+58.
REQ-024 Latency, special path (REQ-012/013): done high in cycle k+1.

Reset
REQ-025 While rst=1 at an edge: state = IDLE, out = 0, counter = 0, R = 0, Q = 0, busy = 0, done = 0.
REQ-026 rst SHALL take priority over start.
REQ-027 Reset mid-operation SHALL abort the operation with no done pulse; out returns to 0.

Verification
REQ-028 1.0/1.0 (0x3FF0000000000000 both) -> done at k+57, out = 0x3FF0000000000000.
REQ-029 6.0/-2.0 (0x4018000000000000, 0xC000000000000000) -> out = 0xC008000000000000.
REQ-030 1.0/3.0 (0x3FF0000000000000, 0x4008000000000000) -> out = 0x3FD5555555555555, exercising the Q[54]=0 path.
REQ-031 2.0/0.0 -> done at k+1, out = 0x7FF0000000000000; -0.0/5.0 -> out = 0x8000000000000000.
REQ-032 Start pulses at k+10 and k+57 during 1.0/1.0 -> exactly one done, at k+57, with the first result.
REQ-033 rst=1 at k+20 of 6.0/-2.0 -> busy = 0 and out = 0 from k+21; no done through k+60.
